reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-port register file for the datapath: 2^D registers of W bits, NR combinational read ports plus a dedicated R0 read, one primary op-encoded write port (write / clear / increment / decrement / overflow-capture), and one secondary plain write port for the load path. It adds a carry/borrow flag, configurable same-cycle write-to-read bypass, and synchronous active-low reset. It replaces the fixed 8×8 flag-driven register file in the core datapath.

## Interface
- W, 8, register width in bits (≥2)
- D, 3, address width; 2^D registers
- NR, 2, number of general read ports (≥1)
- BYPASS, 1, 1 = reads return the value being written this cycle; 0 = reads return stored value
- CLK  in  1  clock; all state updates on rising edge
- ResetN  in  1  synchronous, active-low reset
- RegWrite  in  1  enables primary write port
- WrOp  in  3  primary op (rf_op_t)
- writeReg  in  D  primary destination
- writeValue  in  W  primary data for OP_WRITE
- ovValue  in  1  bit captured by OP_OV
- WrEn1  in  1  secondary write enable
- WrAddr1  in  D  secondary destination
- WrData1  in  W  secondary data
- SrcAddr  in  NR×D  packed read addresses; port i = bits [i*D +: D]
- ReadData  out  NR×W  packed read data; port i = bits [i*W +: W]
- ReadR0  out  W  contents of register 0
- CarryOut  out  1  carry/borrow flag from last INC/DEC

## Operation
- Primary op, applied to reg[writeReg] when RegWrite=1:
  - OP_WRITE (0): writeValue
  - OP_CLEAR (1): 0
  - OP_INC (2): reg+1 mod 2^W; CarryOut←1 iff old value all-ones, else 0
  - OP_DEC (3): reg−1 mod 2^W; CarryOut←1 iff old value 0 (borrow), else 0
  - OP_OV (4): {(W−1)'b0, ovValue}
  - 5–7: NOP (no register or flag change)
- CarryOut changes only on an executed INC/DEC; all other ops and idle cycles hold it.
- Secondary port: WrEn1=1 writes WrData1 to reg[WrAddr1].
- Both ports targeting the same address in one cycle: primary wins if RegWrite=1 and WrOp is not a NOP; otherwise the secondary write takes effect.
- Both ports targeting different addresses: both writes commit.
- Reads are combinational and fully independent; any number of ports may read the same address.
- BYPASS=1: a read of an address being written this cycle returns the post-edge value, with the same priority rules as above. This applies to ReadData and ReadR0. NOP ops are not bypassed.
- BYPASS=0: reads always return stored contents.
- Register 0 is an ordinary writable register; ReadR0 mirrors it.

## Timing
- Reset: on a rising CLK edge with ResetN=0, all registers ←0 and CarryOut←0.
  - Reset dominates any write presented in the same cycle; that write is discarded.
  - All outputs read 0 from the edge onward (with BYPASS=1, while ResetN=0 the bypass still reflects the pending write; the value is not committed).
- Write latency: the value is committed at the rising edge where enable and op are sampled.
  - Visible on reads after that edge (BYPASS=0).
  - Visible combinationally in the same cycle (BYPASS=1).
- INC/DEC read-modify-write completes in one cycle. Back-to-back INCs on the same register increment on every edge (no hazard).
- No handshake; the port is always ready; throughput is one primary plus one secondary write per cycle.

## Structure
- Package regfile_pkg holds:
  - typedef enum logic [2:0] rf_op_t: OP_WRITE, OP_CLEAR, OP_INC, OP_DEC, OP_OV
  - default constants RF_W=8, RF_D=3
- Sub-module rf_next_val: combinational. Inputs: old value, op, writeValue, ovValue. Outputs: next value, carry, carry-update enable. It is instantiated once and shared by the commit and bypass paths.
- Top level holds the register array, CarryOut flop, port-priority mux, and the generate loop over NR read ports.

## Test plan
(W=8, D=3, NR=2, BYPASS=1 unless noted)
1. Write r1=0x5A, r2=0x33, set CarryOut via INC on 0xFF, then ResetN=0 for one edge → all SrcAddr reads, ReadR0, and CarryOut are 0. A write presented during reset is not committed.
2. OP_WRITE r1=0xFE; INC → 0xFF, CarryOut=0; INC → 0x00, CarryOut=1; RegWrite=0 with writeValue=0xAA → r1 stays 0x00.
3. r3=0x00, DEC → 0xFF, CarryOut=1; CLEAR r3 → 0x00, CarryOut holds 1; WrOp=6 → no change.
4. Primary WRITE r2=0x11 plus WrEn1 r2=0x22 in the same cycle → r2=0x11. Primary r4=0x44 plus secondary r5=0x55 → both committed.
5. Primary WRITE r6=0xA5 with SrcAddr={6,6} → both ReadData ports show 0xA5 before the edge. Rebuild with BYPASS=0 → old value before the edge, 0xA5 after.
6. OP_OV with ovValue=1 to r7 → 0x01. WRITE r0=0xCC → ReadR0=0xCC (same cycle with BYPASS=1).

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared op encoding and default geometry for the multi-port register file
package regfile_pkg;

    localparam int RF_W = 8;
    localparam int RF_D = 3;

    typedef enum logic [2:0] {
        OP_WRITE = 3'd0,
        OP_CLEAR = 3'd1,
        OP_INC   = 3'd2,
        OP_DEC   = 3'd3,
        OP_OV    = 3'd4
    } rf_op_t;

    // Encodings 5..7 are reserved and must leave registers and flag untouched.
    function automatic logic op_is_exec(input logic [2:0] op);
        return op <= OP_OV;
    endfunction

endpackage

// File: rtl/rf_next_val.sv
// rtl/rf_next_val.sv - next-value and carry computation for one primary-port op
module rf_next_val
    import regfile_pkg::*;
#(
    parameter int W = RF_W
) (
    input  logic [W-1:0] old_val,
    input  logic [2:0]   op,
    input  logic [W-1:0] write_value,
    input  logic         ov_value,
    output logic [W-1:0] next_val,
    output logic         carry,
    output logic         carry_en
);

    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        next_val = old_val;
        carry    = 1'b0;
        carry_en = 1'b0;
        case (op)
            OP_WRITE: next_val = write_value;
            OP_CLEAR: next_val = '0;
            OP_INC: begin
                next_val = old_val + ONE;
                carry    = &old_val;
                carry_en = 1'b1;
            end
            OP_DEC: begin
                next_val = old_val - ONE;
                carry    = ~|old_val;
                carry_en = 1'b1;
            end
            OP_OV:    next_val = {{(W-1){1'b0}}, ov_value};
            default:  next_val = old_val;
        endcase
    end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - 2^D x W register file: NR read ports + R0, op-encoded primary write, plain secondary write
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int W      = RF_W,
    parameter int D      = RF_D,
    parameter int NR     = 2,
    parameter int BYPASS = 1
) (
    input  logic            CLK,
    input  logic            ResetN,
    input  logic            RegWrite,
    input  logic [2:0]      WrOp,
    input  logic [D-1:0]    writeReg,
    input  logic [W-1:0]    writeValue,
    input  logic            ovValue,
    input  logic            WrEn1,
    input  logic [D-1:0]    WrAddr1,
    input  logic [W-1:0]    WrData1,
    input  logic [NR*D-1:0] SrcAddr,
    output logic [NR*W-1:0] ReadData,
    output logic [W-1:0]    ReadR0,
    output logic            CarryOut
);

    localparam int N = 1 << D;

    logic [W-1:0] regs [N];
    logic         carry_q;
    logic         prim_active;
    logic [W-1:0] prim_val;
    logic         prim_carry;
    logic         prim_carry_en;

    assign prim_active = RegWrite && op_is_exec(WrOp);

    // Single instance feeds both the commit and the bypass path.
    rf_next_val #(.W(W)) u_next (
        .old_val    (regs[writeReg]),
        .op         (WrOp),
        .write_value(writeValue),
        .ov_value   (ovValue),
        .next_val   (prim_val),
        .carry      (prim_carry),
        .carry_en   (prim_carry_en)
    );

    // Primary assignment is last so it overrides the secondary on an address clash.
    always_ff @(posedge CLK) begin
        if (!ResetN) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
            carry_q <= 1'b0;
        end else begin
            if (WrEn1) begin
                regs[WrAddr1] <= WrData1;
            end
            if (prim_active) begin
                regs[writeReg] <= prim_val;
                if (prim_carry_en) begin
                    carry_q <= prim_carry;
                end
            end
        end
    end

    assign CarryOut = carry_q;

    // Index NR is the dedicated R0 port; it shares the bypass logic of the general ports.
    for (genvar i = 0; i <= NR; i++) begin : g_rd
        logic [D-1:0] addr;
        logic [W-1:0] val;

        if (i < NR) begin : g_addr_src
            assign addr = SrcAddr[i*D +: D];
        end else begin : g_addr_r0
            assign addr = '0;
        end

        always_comb begin
            val = regs[addr];
            if (BYPASS != 0) begin
                if (prim_active && (addr == writeReg)) begin
                    val = prim_val;
                end else if (WrEn1 && (addr == WrAddr1)) begin
                    val = WrData1;
                end
            end
        end

        if (i < NR) begin : g_out_src
            assign ReadData[i*W +: W] = val;
        end else begin : g_out_r0
            assign ReadR0 = val;
        end
    end

endmodule
